cla_pipelined_group_adder: RTL
==============================

// Module: cla_pipelined_group_adder
// PURPOSE
//  Downstream consumer of the 4-bit group G/P stage: a WIDTH-bit, 2-stage pipelined carry-lookahead adder.
//  Stage 1 slices the operands into 4-bit groups and registers each group's generate/propagate (G/P).
//  Stage 2 resolves the inter-group carries by lookahead, forms the per-group sums and registers the result.
//  Valid/ready handshake on both sides; exports block-level G/P so instances can be cascaded.
// PARAMETERS
//  WIDTH   16   operand width; must be a multiple of 4 (NG = WIDTH/4 groups); illegal values -> elaboration error
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      a, b and c_in are valid this cycle
//  in_ready   out  1      block accepts an input beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry into bit 0
//  out_valid  out  1      sum, c_out, g_blk and p_blk are valid
//  out_ready  in   1      consumer accepts the output beat
//  sum        out  WIDTH  (a+b+c_in) mod 2^WIDTH
//  c_out      out  1      carry out of bit WIDTH-1
//  g_blk      out  1      block generate over all NG groups
//  p_blk      out  1      block propagate = AND of all group P
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=0, out_valid=0; sum, c_out, g_blk and p_blk clear to 0; all stage-1 registers clear to 0.
//  - Per-bit terms: g[i] = a[i]&b[i]; p[i] = a[i]|b[i] (inclusive-OR propagate).
//  - Group k (bits 4k+3..4k): G = g3 | g2&p3 | g1&p2&p3 | g0&p1&p2&p3; P = p0&p1&p2&p3.
//  - Stage 1 registers a, b, c_in, G[NG-1:0], P[NG-1:0] and s1_valid.
//  - Stage 2 carries: C[0] = c_in; C[k+1] = G[k] | P[k]&C[k].
//    - Each group's 4 sum bits ripple from C[k] (sum bit = a^b^carry).
//    - c_out = C[NG]. g_blk = C[NG] computed with c_in forced to 0. p_blk = &P.
//  - Handshake:
//    - Input beat: in_valid & in_ready. Output beat: out_valid & out_ready.
//    - out_valid/sum/c_out/g_blk/p_blk stay stable until the output beat completes.
//    - Stage 2 loads when s1_valid & (!out_valid | out_ready).
//    - in_ready = !s1_valid | !out_valid | out_ready (combinational; no in_valid dependence).
//    - Stage 1 loads on an input beat. If stage 1 advances with no new input beat, s1_valid clears.
//  - Latency: accepted at edge N -> out_valid high after edge N+1 (2 register stages).
//    - Throughput: 1 beat/cycle while out_ready=1.
//  - Full: s1_valid=1, out_valid=1, out_ready=0 -> in_ready=0; both stages hold.
//  - Simultaneous out-beat + in-beat at full: both stages shift; no bubble, no loss.
//  - Wrap-around: sum truncates to WIDTH; c_out carries the overflow.
//  - Reset mid-operation: in-flight beats discarded; outputs 0 while rst_n=0.
//  - After reset release: out_valid=0, in_ready=1.
//  - No X propagation: registered data changes only on a load.
// TESTING
//  1 a=16'hFFFF, b=16'h0001, c_in=0 -> 2 cycles later: sum=16'h0000, c_out=1, g_blk=1, p_blk=1
//  2 a=16'h1234, b=16'h4321, c_in=1 -> sum=16'h5556, c_out=0, g_blk=0
//  3 hold out_ready=0, push 3 beats:
//    - in_ready drops after 2 beats are accepted;
//    - sum holds the 1st result;
//    - raise out_ready -> results drain in order, none lost.
//  4 continuous in_valid and out_ready -> one result per cycle; c_out correct on each 0xFFFF+0xFFFF+1 (sum=16'hFFFF, c_out=1)
//  5 assert rst_n=0 with both stages full ->
//    - outputs 0 immediately (async);
//    - after release, out_valid=0 and no stale beat appears.
//  6 10k random a/b/c_in with random stalls, WIDTH=16 and WIDTH=32 -> {c_out,sum} == a+b+c_in for every beat

Source files
------------

// File: rtl/cla_pipelined_group_adder.sv
// Two-stage pipelined carry-lookahead adder built from 4-bit groups.
// Stage 1 registers group G/P; stage 2 resolves carries and sums.
module cla_pipelined_group_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             g_blk,
    output logic             p_blk
);

    localparam int NG = WIDTH / 4;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;
    logic [NG-1:0]    gg_q, gp_q, gg_d, gp_d;
    logic             s1_valid_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             gblk_q, gblk_d;
    logic             pblk_q, pblk_d;

    logic       in_beat, s2_load;
    logic [3:0] gi, pi;
    logic       cy, cy0, ck, rc;

    assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
    assign in_beat  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);

    always_comb begin
        gi   = '0;
        pi   = '0;
        gg_d = '0;
        gp_d = '0;
        for (int k = 0; k < NG; k++) begin
            gi = a[4*k +: 4] & b[4*k +: 4];
            pi = a[4*k +: 4] | b[4*k +: 4];
            gg_d[k] = gi[3] | (gi[2] & pi[3]) | (gi[1] & pi[2] & pi[3])
                    | (gi[0] & pi[1] & pi[2] & pi[3]);
            gp_d[k] = &pi;
        end
    end

    // Group carries come from lookahead; bits inside a group ripple from C[k].
    always_comb begin
        sum_d = '0;
        cy    = cin_q;
        cy0   = 1'b0;
        ck    = 1'b0;
        rc    = 1'b0;
        for (int k = 0; k < NG; k++) begin
            ck = cy;
            rc = ck;
            for (int j = 0; j < 4; j++) begin
                sum_d[4*k+j] = a_q[4*k+j] ^ b_q[4*k+j] ^ rc;
                rc = (a_q[4*k+j] & b_q[4*k+j])
                   | ((a_q[4*k+j] | b_q[4*k+j]) & rc);
            end
            cy  = gg_q[k] | (gp_q[k] & ck);
            cy0 = gg_q[k] | (gp_q[k] & cy0);
        end
        cout_d = cy;
        gblk_d = cy0;
        pblk_d = &gp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            gg_q       <= '0;
            gp_q       <= '0;
            s1_valid_q <= 1'b0;
        end else if (in_beat) begin
            a_q        <= a;
            b_q        <= b;
            cin_q      <= c_in;
            gg_q       <= gg_d;
            gp_q       <= gp_d;
            s1_valid_q <= 1'b1;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            gblk_q      <= 1'b0;
            pblk_q      <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= 1'b1;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            gblk_q      <= gblk_d;
            pblk_q      <= pblk_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = cout_q;
    assign g_blk     = gblk_q;
    assign p_blk     = pblk_q;

endmodule
